// File: rtl/store_buffer_pkg.sv
// Shared definitions for the stage-3/stage-4 store buffer: entry layout,
// store type encodings and the word-granular address comparison.
package store_buffer_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      stype;
    } store_entry_t;

    // Conservative ordering check: any overlap within the same 32-bit word counts.
    function automatic logic same_word(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return (a[XLEN-1:2] == b[XLEN-1:2]);
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Combinational load-vs-pending-store comparator; only occupied entries can hit.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [XLEN-1:0]            ld_addr,
    input  logic [DEPTH-1:0][XLEN-1:0] addrs,
    input  logic [DEPTH-1:0]           occupied,
    output logic                       hit
);

    logic unused_low_s;

    // OR-reduce the per-entry word matches; byte offsets never take part.
    always_comb begin
        hit          = 1'b0;
        unused_low_s = ^ld_addr[1:0];
        for (int i = 0; i < DEPTH; i++) begin
            unused_low_s = unused_low_s ^ (^addrs[i][1:0]);
            if (occupied[i] && same_word(addrs[i], ld_addr)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between execute and data memory: stores retire here
// and drain one per cycle whenever the stage-4 load is not using the port.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic [XLEN-1:0]              st_addr,
    input  logic [XLEN-1:0]              st_data,
    input  logic [2:0]                   st_type,
    output logic                         st_ready,
    input  logic                         ld_valid,
    input  logic [XLEN-1:0]              ld_addr,
    output logic                         ld_stall,
    input  logic                         drain_all,
    output logic                         mem_write,
    output logic [XLEN-1:0]              mem_addr,
    output logic [XLEN-1:0]              mem_data,
    output logic [2:0]                   mem_type,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    store_entry_t [DEPTH-1:0]     entries_r;
    logic [PTR_W-1:0]             head_r;
    logic [PTR_W-1:0]             tail_r;
    logic [CNT_W-1:0]             count_r;

    logic [DEPTH-1:0]             occupied_s;
    logic [DEPTH-1:0][XLEN-1:0]   addrs_s;
    logic [PTR_W-1:0]             offset_s;
    logic                         hit_s;
    logic                         full_s;
    logic                         empty_s;
    logic                         push_s;
    logic                         pop_s;

    // An entry is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        occupied_s = '0;
        addrs_s    = '0;
        offset_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_s      = PTR_W'(i) - head_r;
            occupied_s[i] = (CNT_W'(offset_s) < count_r);
            addrs_s[i]    = entries_r[i].addr;
        end
    end

    store_buffer_match #(
        .DEPTH    (DEPTH)
    ) u_match (
        .ld_addr  (ld_addr),
        .addrs    (addrs_s),
        .occupied (occupied_s),
        .hit      (hit_s)
    );

    // Handshake and drain decisions; a stalled load frees the port so draining cannot deadlock.
    always_comb begin
        full_s   = (count_r == CNT_W'(DEPTH));
        empty_s  = (count_r == {CNT_W{1'b0}});
        st_ready = !full_s && !drain_all;
        ld_stall = ld_valid && hit_s;
        push_s   = st_valid && st_ready;
        pop_s    = !empty_s && (drain_all || !ld_valid || ld_stall);
        if (pop_s) begin
            mem_write = 1'b1;
        end else begin
            mem_write = 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries_r <= '0;
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
        end else begin
            if (push_s) begin
                entries_r[tail_r] <= '{addr: st_addr, data: st_data, stype: st_type};
                tail_r            <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign mem_addr = entries_r[head_r].addr;
    assign mem_data = entries_r[head_r].data;
    assign mem_type = entries_r[head_r].stype;
    assign count    = count_r;
    assign empty    = empty_s;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic [2:0]  st_type = 3'b000;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic        ld_stall;
    logic        drain_all = 1'b0;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  mem_type;
    logic [2:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_type   (st_type),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_stall  (ld_stall),
        .drain_all (drain_all),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_type  (mem_type),
        .count     (count),
        .empty     (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit s;
        s = 1'b0;
        if (ld_valid) begin
            foreach (q[k]) begin
                if (q[k].a[31:2] == ld_addr[31:2]) s = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic bit model_pop();
        return (q.size() > 0) && (drain_all || !ld_valid || model_stall());
    endfunction

    // Reference model state update.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            ent_t e;
            do_pop  = model_pop();
            do_push = st_valid && (q.size() < DEPTH) && !drain_all;
            e.a = st_addr;
            e.d = st_data;
            e.t = st_type;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    end

    // Compare the DUT against the model each cycle.
    always @(negedge clock) begin
        if (!reset) begin
            chk("m_count", {29'b0, count}, q.size());
            chk("m_empty", {31'b0, empty}, (q.size() == 0) ? 32'd1 : 32'd0);
            chk("m_st_ready", {31'b0, st_ready}, ((q.size() < DEPTH) && !drain_all) ? 32'd1 : 32'd0);
            chk("m_ld_stall", {31'b0, ld_stall}, model_stall() ? 32'd1 : 32'd0);
            chk("m_mem_write", {31'b0, mem_write}, model_pop() ? 32'd1 : 32'd0);
            if (q.size() > 0) begin
                chk("m_mem_addr", mem_addr, q[0].a);
                chk("m_mem_data", mem_data, q[0].d);
                chk("m_mem_type", {29'b0, mem_type}, {29'b0, q[0].t});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_type  = t;
    endtask

    initial begin
        // Reset then idle
        at_neg();
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        at_neg();
        chk("idle_empty", {31'b0, empty}, 32'd1);
        chk("idle_st_ready", {31'b0, st_ready}, 32'd1);
        chk("idle_mem_write", {31'b0, mem_write}, 32'd0);
        chk("idle_ld_stall", {31'b0, ld_stall}, 32'd0);
        chk("idle_count", {29'b0, count}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_data", mem_data, 32'd0);
        chk("idle_mem_type", {29'b0, mem_type}, 32'd0);

        // Single SW
        tick();
        push(32'h100, 32'hDEADBEEF, ST_SW);
        ld_valid = 1'b0;
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("sw_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sw_mem_addr", mem_addr, 32'h100);
        chk("sw_mem_data", mem_data, 32'hDEADBEEF);
        chk("sw_mem_type", {29'b0, mem_type}, 32'd2);
        tick();
        at_neg();
        chk("sw_empty_after", {31'b0, empty}, 32'd1);

        // Fill and hold behind a non-matching load
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            push(32'h300 + 32'(4 * k), 32'hA0 + 32'(k), ST_SW);
        end
        tick();
        push(32'h400, 32'hFF, ST_SW);
        at_neg();
        chk("fill_count", {29'b0, count}, 32'd4);
        chk("fill_st_ready", {31'b0, st_ready}, 32'd0);
        chk("fill_mem_write", {31'b0, mem_write}, 32'd0);
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("fill_5th_ignored", {29'b0, count}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            ld_valid = 1'b0;
            at_neg();
            chk("fill_drain_write", {31'b0, mem_write}, 32'd1);
            chk("fill_drain_addr", mem_addr, 32'h300 + 32'(4 * k));
            chk("fill_drain_data", mem_data, 32'hA0 + 32'(k));
        end
        tick();
        at_neg();
        chk("fill_empty", {31'b0, empty}, 32'd1);

        // Load conflict on a byte store in the same word
        tick();
        push(32'h103, 32'h55, ST_SB);
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        at_neg();
        chk("conf_same_cycle_excluded", {31'b0, ld_stall}, 32'd0);
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("conf_stall", {31'b0, ld_stall}, 32'd1);
        chk("conf_mem_write", {31'b0, mem_write}, 32'd1);
        chk("conf_mem_addr", mem_addr, 32'h103);
        chk("conf_mem_type", {29'b0, mem_type}, 32'd0);
        tick();
        at_neg();
        chk("conf_released", {31'b0, ld_stall}, 32'd0);

        // Simultaneous push and pop at count 2, across pointer wrap
        ld_addr = 32'h200;
        tick();
        push(32'h500, 32'h1, ST_SH);
        tick();
        push(32'h504, 32'h2, ST_SH);
        tick();
        ld_valid = 1'b0;
        push(32'h508, 32'h3, ST_SH);
        at_neg();
        chk("pp_count", {29'b0, count}, 32'd2);
        chk("pp_head", mem_addr, 32'h500);
        for (int j = 1; j < 6; j++) begin
            tick();
            push(32'h500 + 32'(4 * (j + 2)), 32'(j + 3), ST_SH);
            at_neg();
            chk("pp_count", {29'b0, count}, 32'd2);
            chk("pp_head", mem_addr, 32'h500 + 32'(4 * j));
        end
        tick();
        st_valid = 1'b0;
        repeat (3) tick();

        // drain_all with three entries and a non-conflicting load
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        for (int k = 0; k < 3; k++) begin
            push(32'h600 + 32'(4 * k), 32'h60 + 32'(k), ST_SW);
            tick();
        end
        push(32'h700, 32'h70, ST_SW);
        drain_all = 1'b1;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("da_st_ready", {31'b0, st_ready}, 32'd0);
            chk("da_mem_write", {31'b0, mem_write}, 32'd1);
            chk("da_mem_addr", mem_addr, 32'h600 + 32'(4 * k));
            tick();
        end
        at_neg();
        chk("da_empty", {31'b0, empty}, 32'd1);
        tick();
        drain_all = 1'b0;
        st_valid  = 1'b0;

        // Mid-operation reset discards pending stores at once
        push(32'h800, 32'h8, ST_SW);
        tick();
        push(32'h804, 32'h9, ST_SW);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("arst_empty", {31'b0, empty}, 32'd1);
        chk("arst_count", {29'b0, count}, 32'd0);
        chk("arst_mem_write", {31'b0, mem_write}, 32'd0);
        tick();
        reset = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            st_valid  = ($urandom_range(0, 9) < 6);
            st_addr   = 32'h1000 + 32'($urandom_range(0, 31));
            st_data   = $urandom;
            st_type   = 3'($urandom_range(0, 2));
            ld_valid  = ($urandom_range(0, 9) < 6);
            ld_addr   = 32'h1000 + 32'($urandom_range(0, 31));
            drain_all = ($urandom_range(0, 9) == 0);
        end
        tick();
        st_valid  = 1'b0;
        ld_valid  = 1'b0;
        drain_all = 1'b0;
        repeat (8) tick();
        at_neg();
        chk("final_empty", {31'b0, empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
